dmem_arbiter: RTL

// Shares the single-port synchronous data RAM between the CPU data port and a host/debug port.

---
 rtl/bpu2_mem_pkg.sv | 16 +
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bpu2_mem_pkg.sv
// Shared memory-side types for the data and (future) instruction arbiters.
package bpu2_mem_pkg;

    // Which requester owns a RAM access (current grant or a read in flight).
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    // Width needed to count 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: shares one single-port synchronous RAM between the CPU
// data port and a host/debug port. The CPU wins by default; a saturating wait
// counter forces a host slot (stalling the CPU) once the host has waited
// MAX_WAIT cycles. Read data returns one cycle after the access and is steered
// to whichever requester issued it, with the last value held on each side.
module dmem_arbiter
    import bpu2_mem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              sync_rst,

    input  logic              clk_en,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int WAIT_W = cnt_width(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic              cpu_act;
    logic              force_host;
    owner_t            grant;
    owner_t            rd_owner_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              rd_cpu_now;
    logic              rd_host_now;

    // The CPU only counts as requesting while its clock is enabled.
    assign cpu_act    = clk_en & cpu_req;
    assign force_host = host_req & (wait_cnt == WAIT_MAX);

    // Per-cycle grant: starved host first, then CPU, then host; nothing in reset.
    always_comb begin
        grant = OWN_NONE;
        if (sync_rst) begin
            if (force_host) begin
                grant = OWN_HOST;
            end else if (cpu_act) begin
                grant = OWN_CPU;
            end else if (host_req) begin
                grant = OWN_HOST;
            end
        end
    end

    assign cpu_stall = cpu_act & (grant == OWN_HOST);
    assign host_ack  = (grant == OWN_HOST);

    // RAM port follows the granted requester; idle port drives zeros.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (grant)
            OWN_CPU: begin
                ram_en    = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            OWN_HOST: begin
                ram_en    = 1'b1;
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
            end
            default: begin
            end
        endcase
    end

    // A read registered just before reset asserts must not surface, so the
    // live steering is also qualified by sync_rst.
    assign rd_cpu_now  = sync_rst & (rd_owner_q == OWN_CPU);
    assign rd_host_now = sync_rst & (rd_owner_q == OWN_HOST);

    assign cpu_rdata   = rd_cpu_now  ? ram_rdata : cpu_rdata_q;
    assign host_rdata  = rd_host_now ? ram_rdata : host_rdata_q;
    assign host_rvalid = rd_host_now;

    // Wait counter, read-owner tracking and held read data.
    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            wait_cnt     <= '0;
            rd_owner_q   <= OWN_NONE;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (!host_req || (grant == OWN_HOST)) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            rd_owner_q <= (ram_en && !ram_we) ? grant : OWN_NONE;

            if (rd_owner_q == OWN_CPU) begin
                cpu_rdata_q <= ram_rdata;
            end
            if (rd_owner_q == OWN_HOST) begin
                host_rdata_q <= ram_rdata;
            end
        end
    end

endmodule
